// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the fetch/branch handshake between the PC sequencer and the rest of
// the core (branch unit, decoder, instruction-memory interface).
//
// Signals:
//   Imem_Ready     core -> seq   fetch at PC completed, instruction retires
//   Branch_Taken   core -> seq   current instruction redirects control flow
//   Branch_Target  core -> seq   redirect address
//   Halt_Req       core -> seq   ECALL/EBREAK retiring, stop afterwards
//   Resume         core -> seq   leave HALT
//   Fetch_Req      seq -> core   fetch request at PC
//   PC             seq -> core   architectural PC (registered)
//   PC_Src_1       seq -> core   PC+4, sequential input of next-PC mux
//   PC_Src_2       seq -> core   Branch_Target, redirect input of next-PC mux
//   PC_SRC         seq -> core   next-PC mux select (1 = PC_Src_2)
//   Halted         seq -> core   sequencer is in HALT
//   Misalign_Err   seq -> core   sticky misaligned-target fault
//   Retire_Count   seq -> core   retired-instruction counter
//
// Modports:
//   master - the sequencer side (drives PC and fetch control)
//   slave  - the core / memory side
interface pc_sequencer_if;
    logic        Imem_Ready;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic        Halt_Req;
    logic        Resume;
    logic        Fetch_Req;
    logic [31:0] PC;
    logic [31:0] PC_Src_1;
    logic [31:0] PC_Src_2;
    logic        PC_SRC;
    logic        Halted;
    logic        Misalign_Err;
    logic [31:0] Retire_Count;

    modport master (
        input  Imem_Ready,
        input  Branch_Taken,
        input  Branch_Target,
        input  Halt_Req,
        input  Resume,
        output Fetch_Req,
        output PC,
        output PC_Src_1,
        output PC_Src_2,
        output PC_SRC,
        output Halted,
        output Misalign_Err,
        output Retire_Count
    );

    modport slave (
        output Imem_Ready,
        output Branch_Taken,
        output Branch_Target,
        output Halt_Req,
        output Resume,
        input  Fetch_Req,
        input  PC,
        input  PC_Src_1,
        input  PC_Src_2,
        input  PC_SRC,
        input  Halted,
        input  Misalign_Err,
        input  Retire_Count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer for the single-cycle RV32I core. Owns the
// architectural PC, drives the next-PC mux select, and gates instruction
// fetch through a post-reset boot delay, a halt/resume handshake and a
// sticky misaligned-target fault.
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset
//   BOOT_DELAY    cycles spent in BOOT before the first fetch (1..255)
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    pc_sequencer_if.master (see rtl/pc_sequencer_if.sv)
//
// Build option:
//   PC_RETIRE_COUNT_EN  when defined, the 32-bit retired-instruction counter
//                       is implemented; otherwise Retire_Count is tied to 0.
//
// States:
//   state    | meaning
//   ST_BOOT  | post-reset delay, no fetch, boot counter running
//   ST_RUN   | fetching; an instruction retires on each Imem_Ready
//   ST_HALT  | stopped after ECALL/EBREAK, waiting for Resume
//   ST_FAULT | misaligned branch target seen, terminal until reset
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_DELAY   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [7:0] BOOT_LOAD = 8'(BOOT_DELAY);

    state_t      state_q, state_d;
    logic [7:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;

    logic        target_aligned;
    logic        retire;
    logic        misalign;
    logic        redirect;
    logic [31:0] pc_plus4;

    // Retire qualification shared by the FSM, the mux select and the counter.
    always_comb begin
        target_aligned = (bus.Branch_Target[1:0] == 2'b00);
        retire         = (state_q == ST_RUN) && bus.Imem_Ready;
        misalign       = retire && bus.Branch_Taken && !target_aligned;
        redirect       = retire && bus.Branch_Taken && target_aligned;
        pc_plus4       = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_LOAD;
            pc_q       <= RESET_VECTOR;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;

        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q - 8'd1;
                // <= rather than == so an out-of-range delay of 0 cannot
                // wrap the counter and stall boot for 256 cycles.
                if (boot_cnt_q <= 8'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (misalign) begin
                    // Misalign wins over halt; PC holds at the faulting
                    // instruction for post-mortem inspection.
                    state_d = ST_FAULT;
                end else if (retire) begin
                    pc_d = redirect ? bus.Branch_Target : pc_plus4;
                    if (bus.Halt_Req) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (bus.Resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        halted_d   = (state_d == ST_HALT);
        misalign_d = misalign_q | misalign;
    end

`ifdef PC_RETIRE_COUNT_EN
    logic [31:0] retire_cnt_q;
    logic        count_en;

    // Misaligned branches never complete, so they are not counted.
    always_comb begin
        count_en = retire && !misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= 32'h0;
        end else if (count_en) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign bus.Retire_Count = retire_cnt_q;
`else
    assign bus.Retire_Count = 32'h0;
`endif

    assign bus.Fetch_Req    = (state_q == ST_RUN);
    assign bus.PC           = pc_q;
    assign bus.PC_Src_1     = pc_plus4;
    assign bus.PC_Src_2     = bus.Branch_Target;
    assign bus.PC_SRC       = redirect;
    assign bus.Halted       = halted_q;
    assign bus.Misalign_Err = misalign_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle RV32I core. It owns the architectural PC register and drives the select line of the next-PC mux that chooses between the sequential address and a branch/jump target. It also gates instruction fetch through a post-reset boot delay, a halt/resume handshake and a sticky misaligned-target fault. The block sits between the branch unit/decoder and the instruction-memory interface.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000: PC value loaded on reset.
- `BOOT_DELAY`, default 4: cycles spent in BOOT before the first fetch; legal range 1..255.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `Imem_Ready`  in  1: instruction memory completed the fetch at `PC`; the instruction retires this cycle.
- `Branch_Taken`  in  1: the current instruction redirects control flow.
- `Branch_Target`  in  32: redirect address, valid when `Branch_Taken`=1.
- `Halt_Req`  in  1: current instruction is ECALL/EBREAK; stop after it retires.
- `Resume`  in  1: leave HALT.
- `Fetch_Req`  out  1: fetch request at `PC`.
- `PC`  out  32: current PC (registered).
- `PC_Src_1`  out  32: `PC`+4, the sequential input of the next-PC mux.
- `PC_Src_2`  out  32: `Branch_Target` passed through, the redirect input of the next-PC mux.
- `PC_SRC`  out  1: mux select; 1 selects `PC_Src_2`.
- `Halted`  out  1: state is HALT.
- `Misalign_Err`  out  1: sticky fault flag.
- `Retire_Count`  out  32: retired-instruction counter.

## Operation
- The FSM has four states: BOOT, RUN, HALT and FAULT.
- **BOOT:**
  - `Fetch_Req`=0 and a down-counter is loaded with `BOOT_DELAY`.
  - The counter decrements each cycle. On the cycle it reads 1, the next state is RUN.
- **RUN:**
  - `Fetch_Req`=1.
  - An instruction retires when `Imem_Ready`=1. With `Imem_Ready`=0, `PC` holds and all other inputs are ignored.
  - Retire priority:
    1. **Misalign:** `Branch_Taken`=1 and `Branch_Target[1:0]`≠0. Go to FAULT, set `Misalign_Err`, hold `PC`, do not count the instruction.
    2. **Redirect:** `Branch_Taken`=1 with an aligned target. `PC` ← `Branch_Target`.
    3. **Sequential:** otherwise `PC` ← `PC`+4.
  - For cases 2 and 3, `Retire_Count` increments. If `Halt_Req`=1, the next state is HALT, but `PC` still advances.
  - `Halt_Req` together with a misaligned branch resolves to FAULT.
- **HALT:**
  - `Fetch_Req`=0 and `Halted`=1.
  - `Resume`=1 moves to RUN on the next cycle; `PC` is unchanged.
  - `Resume` is ignored in every state other than HALT.
- **FAULT:** `Fetch_Req`=0. This state is terminal until reset.
- **Arithmetic:**
  - `PC`+4 is 32-bit modulo, so 32'hFFFF_FFFC+4 = 0.
  - `Retire_Count` wraps from 32'hFFFF_FFFF to 0.

## Timing
- **Reset values:**
  - `PC`=`RESET_VECTOR`; state=BOOT.
  - `Fetch_Req`=0, `PC_SRC`=0, `Halted`=0, `Misalign_Err`=0, `Retire_Count`=0.
  - `PC_Src_1`=`RESET_VECTOR`+4.
- **Combinational outputs:**
  - `PC_SRC` = (state==RUN) & `Imem_Ready` & `Branch_Taken` & aligned target.
  - `PC_Src_1` is combinational from `PC`.
  - `PC_Src_2` is combinational from `Branch_Target`.
- **Registered outputs:**
  - `PC`, `Retire_Count`, `Halted` and `Misalign_Err` are registered.
  - `Fetch_Req` is decoded from the registered state.
- **Latency:**
  - Release of reset to first `Fetch_Req`=1 is exactly `BOOT_DELAY` cycles.
  - Retire to new `PC` is 1 cycle.
  - `Resume` to `Fetch_Req`=1 is 1 cycle.
- **Reset mid-operation:** asserting `rst_n`=0 in any state returns all outputs to reset values immediately, without waiting for a clock edge.

## Configuration
- The feature is controlled by the macro `PC_RETIRE_COUNT_EN`.
- **Defined:** the 32-bit `Retire_Count` register is implemented as specified above.
- **Undefined:** no counter flops are synthesized and `Retire_Count` is tied to 32'h0. The port remains on the interface.

## Test plan
- **Boot delay:** use `BOOT_DELAY`=4 and `RESET_VECTOR`=32'h100, then release reset. Expect `Fetch_Req`=0 for 4 cycles, then 1 with `PC`=32'h100.
- **Sequential fetch:** hold `Imem_Ready`=1 for 3 cycles with no branch. Expect `PC` sequence 100→104→108→10C and `Retire_Count`=3.
- **Wait states and redirect:** with `Imem_Ready`=0 for 2 cycles, `PC` holds at 10C. Then apply `Imem_Ready`=1, `Branch_Taken`=1, `Branch_Target`=32'h200. Expect `PC_SRC`=1 in that cycle and `PC`=200 next cycle.
- **Halt/resume:** apply `Halt_Req` with `Imem_Ready` at `PC`=200. Expect `PC`=204, `Halted`=1 and `Fetch_Req`=0 while idle. Pulse `Resume`; expect `Fetch_Req`=1 the next cycle with `PC` still 204.
- **Misaligned target:** apply `Branch_Taken` with `Branch_Target`=32'h302 and `Imem_Ready`=1. Expect `Misalign_Err`=1, `PC` to stay 204, `Retire_Count` unchanged and `Fetch_Req`=0. A later `Resume` must have no effect.
- **Wrap and async reset:** preload `PC`=32'hFFFF_FFFC via a redirect and retire once; expect `PC`=0. Then drop `rst_n` mid-cycle; expect outputs to reset before the next edge.
